// File: rtl/arb_pkg.sv
// Shared types and default sizing for the IF/D memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_t;

    localparam int ARB_ADDR_W     = 64;
    localparam int ARB_DATA_W     = 64;
    localparam int ARB_MEM_LAT    = 2;
    localparam int ARB_STARVE_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that flags the final cycle of a fixed-length wait.
// Loaded with N, it reports done on the Nth enabled cycle after the load.
module lat_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between the instruction
// fetch port (IF) and the data port (D). One transaction in flight at a time;
// D normally wins, but after STARVE_MAX consecutive losses IF is forced through.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MEM_LAT    = ARB_MEM_LAT,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT);

    arb_state_t       state;
    port_id_t         cur_port;
    logic [STV_W-1:0] starve_cnt;
    logic             if_force;
    logic             d_win;
    logic             if_win;
    logic             grant;
    logic             lat_done;

    // Pick the winner while idle. Ready is withheld during reset so a requester
    // never sees an acceptance that the reset is about to throw away.
    always_comb begin
        if_force = if_req && (starve_cnt == STARVE_LIM);
        d_win    = (state == IDLE) && !reset && d_req && !if_force;
        if_win   = (state == IDLE) && !reset && if_req && !d_win;
        grant    = d_win || if_win;
    end

    assign if_ready  = if_win;
    assign d_ready   = d_win;
    assign mem_en    = (state == ISSUE);
    assign if_rvalid = (state == RESP) && (cur_port == PORT_IF);
    assign d_rvalid  = (state == RESP) && (cur_port == PORT_D);
    assign busy      = (state != IDLE);

    // Transaction sequencing: grant, one strobe cycle, fixed wait, one response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (grant) state <= ISSUE;
                ISSUE:   state <= WAIT;
                WAIT:    if (lat_done) state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the winning request; these registers drive the memory buses directly
    // and therefore hold their values until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_port  <= PORT_IF;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (d_win) begin
            cur_port  <= PORT_D;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (if_win) begin
            cur_port  <= PORT_IF;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end
    end

    // Count IF losses; any IF win or any idle cycle without an IF request resets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (if_win || !if_req) begin
                starve_cnt <= '0;
            end else if (d_win && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Capture read data on the last wait cycle into the owning port's register;
    // a store returns zero. Each port's data stays put until its next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if ((state == WAIT) && lat_done) begin
            if (cur_port == PORT_IF) begin
                if_rdata <= mem_rdata;
            end else begin
                d_rdata <= mem_we ? '0 : mem_rdata;
            end
        end
    end

    lat_counter #(
        .WIDTH (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (state == ISSUE),
        .load_val (LAT_LOAD),
        .en       (state == WAIT),
        .done     (lat_done)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents feed IF and D, a
// memory model answers exactly MEM_LAT cycles after each strobe, and every
// grant pushes the expected response that is later matched against rvalid.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;
    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] data;
        int          gcyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        rst_q    = 1'b1;
    req_t        if_todo[$];
    req_t        d_todo[$];
    int          if_ack_cnt = 0;
    int          d_ack_cnt  = 0;
    int          if_idx     = 0;
    int          d_idx      = 0;
    bit          if_en      = 1'b1;
    exp_t        sb[$];
    bit          grant_log[$];
    int          grant_cyc_log[$];
    int          busy_from  = 1;
    int          busy_until = 0;
    int          mem_pend_cyc = -1;
    logic [63:0] mem_pend_addr = '0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle number and a registered copy of reset as the DUT saw it.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Memory contents as seen by reads; 0x10 holds the well-known fetch word.
    function automatic logic [63:0] memf(input logic [63:0] a);
        if (a == 64'h10) return 64'hDEAD;
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic applyStimulus(input bit is_d, input bit we, input logic [63:0] addr,
                                 input logic [63:0] wdata);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        if (is_d) d_todo.push_back(r);
        else      if_todo.push_back(r);
    endtask

    // Observe one cycle: reset state, busy, grants, memory strobe and responses.
    task automatic monitorCycle();
        exp_t e;
        logic exp_busy;
        if (rst_q) begin
            checkOutput("rst_ctrl", 64'({if_ready, if_rvalid, d_ready, d_rvalid, mem_en, mem_we, busy}), 64'h0);
            checkOutput("rst_if_rdata", if_rdata, 64'h0);
            checkOutput("rst_d_rdata", d_rdata, 64'h0);
            checkOutput("rst_mem_addr", mem_addr, 64'h0);
            checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
            sb.delete();
            busy_from    = 1;
            busy_until   = 0;
            mem_pend_cyc = -1;
            return;
        end
        exp_busy = (cyc >= busy_from) && (cyc <= busy_until);
        checkOutput("busy", 64'(busy), 64'(exp_busy));
        if (if_ready || d_ready) begin
            checkOutput("one_ready", 64'(if_ready && d_ready), 64'h0);
            checkOutput("ready_in_idle", 64'(exp_busy), 64'h0);
            if (d_ready) begin
                checkOutput("d_ready_req", 64'(d_req), 64'h1);
                e.is_d  = 1'b1;
                e.we    = d_we;
                e.addr  = d_addr;
                e.wdata = d_wdata;
                d_ack_cnt++;
            end else begin
                checkOutput("if_ready_req", 64'(if_req), 64'h1);
                e.is_d  = 1'b0;
                e.we    = 1'b0;
                e.addr  = if_addr;
                e.wdata = '0;
                if_ack_cnt++;
            end
            e.data = e.we ? 64'h0 : memf(e.addr);
            e.gcyc = cyc;
            sb.push_back(e);
            grant_log.push_back(e.is_d);
            grant_cyc_log.push_back(cyc);
            busy_from  = cyc + 1;
            busy_until = cyc + MEM_LAT + 2;
        end
        if (mem_en) begin
            if (sb.size() == 0) begin
                checkOutput("mem_en_orphan", 64'h1, 64'h0);
            end else begin
                e = sb[0];
                checkOutput("mem_en_cyc", 64'(cyc), 64'(e.gcyc + 1));
                checkOutput("mem_we", 64'(mem_we), 64'(e.we));
                checkOutput("mem_addr", mem_addr, e.addr);
                if (e.we) checkOutput("mem_wdata", mem_wdata, e.wdata);
                mem_pend_cyc  = cyc + MEM_LAT;
                mem_pend_addr = mem_addr;
            end
        end
        if (if_rvalid || d_rvalid) begin
            checkOutput("rvalid_one", 64'(if_rvalid && d_rvalid), 64'h0);
            if (sb.size() == 0) begin
                checkOutput("rvalid_orphan", 64'h1, 64'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("rvalid_port", 64'(d_rvalid), 64'(e.is_d));
                checkOutput("rvalid_cyc", 64'(cyc), 64'(e.gcyc + MEM_LAT + 2));
                if (e.is_d) checkOutput("d_rdata", d_rdata, e.data);
                else        checkOutput("if_rdata", if_rdata, e.data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitorCycle();
    endtask

    task automatic waitDrain(input int max_cycles);
        int n = 0;
        while (!(if_ack_cnt == if_todo.size() && d_ack_cnt == d_todo.size() && sb.size() == 0
                 && !busy && !if_req && !d_req) && n < max_cycles) begin
            tick();
            n++;
        end
        if (n >= max_cycles) checkOutput("drain_timeout", 64'h1, 64'h0);
    endtask

    // IF requester: holds each fetch until accepted, drops it while disabled.
    initial begin
        req_t r;
        if_req  = 1'b0;
        if_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (if_ack_cnt != if_idx) begin
                if_req = 1'b0;
                if_idx = if_ack_cnt;
            end
            if (!if_en) begin
                if_req = 1'b0;
            end else if (!if_req && if_idx < if_todo.size()) begin
                r       = if_todo[if_idx];
                if_req  = 1'b1;
                if_addr = r.addr;
            end
        end
    end

    // D requester: holds each load/store until accepted.
    initial begin
        req_t r;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (d_ack_cnt != d_idx) begin
                d_req = 1'b0;
                d_idx = d_ack_cnt;
            end
            if (!d_req && d_idx < d_todo.size()) begin
                r       = d_todo[d_idx];
                d_req   = 1'b1;
                d_we    = r.we;
                d_addr  = r.addr;
                d_wdata = r.wdata;
            end
        end
    end

    // Memory model: valid data only in the cycle MEM_LAT after the strobe.
    initial begin
        mem_rdata = JUNK;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = (cyc == mem_pend_cyc) ? memf(mem_pend_addr) : JUNK;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit starve_ord[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit clear_ord[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int base;
        int n;
        int g;

        reset = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] IF read, D store, D load");
        applyStimulus(1'b0, 1'b0, 64'h10, 64'h0);
        waitDrain(60);
        applyStimulus(1'b1, 1'b1, 64'h40, 64'h55);
        waitDrain(60);
        checkOutput("if_rdata_hold", if_rdata, 64'hDEAD);
        checkOutput("d_rdata_store", d_rdata, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h48, 64'h0);
        waitDrain(60);
        checkOutput("d_rdata_load", d_rdata, memf(64'h48));

        $display("[TB] continuous contention, starvation limit");
        base = grant_log.size();
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 64'h100 + 64'(i * 8), 64'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i[0], 64'h200 + 64'(i * 8), 64'h1000 + 64'(i));
        waitDrain(300);
        if (grant_log.size() < base + 8) begin
            checkOutput("starve_count", 64'(grant_log.size() - base), 64'h8);
        end else begin
            for (int i = 0; i < 8; i++) checkOutput("starve_order", 64'(grant_log[base + i]), 64'(starve_ord[i]));
            for (int i = 1; i < 8; i++)
                checkOutput("grant_gap", 64'(grant_cyc_log[base + i] - grant_cyc_log[base + i - 1]), 64'(MEM_LAT + 3));
        end

        $display("[TB] IF withdraws, loss count clears");
        base = grant_log.size();
        applyStimulus(1'b0, 1'b0, 64'h300, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h400, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h408, 64'h0);
        n = 0;
        while (grant_log.size() < base + 2 && n < 40) begin
            tick();
            n++;
        end
        if (grant_log.size() < base + 2) checkOutput("withdraw_grant_timeout", 64'h1, 64'h0);
        if_en = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h410 + 64'(i * 8), 64'h0);
        if_en = 1'b1;
        waitDrain(300);
        if (grant_log.size() < base + 6) begin
            checkOutput("clear_count", 64'(grant_log.size() - base), 64'h6);
        end else begin
            for (int i = 0; i < 6; i++) checkOutput("clear_order", 64'(grant_log[base + i]), 64'(clear_ord[i]));
        end

        $display("[TB] reset during wait");
        base = grant_log.size();
        applyStimulus(1'b0, 1'b0, 64'h10, 64'h0);
        n = 0;
        while (grant_log.size() == base && n < 20) begin
            tick();
            n++;
        end
        if (grant_log.size() == base) begin
            checkOutput("rst_grant_timeout", 64'h1, 64'h0);
        end else begin
            g = grant_cyc_log[base];
            while (cyc < g + 2) tick();
            @(posedge clk);
            #1 reset = 1'b1;
            tick();
            @(posedge clk);
            #1 reset = 1'b0;
            repeat (6) tick();
            applyStimulus(1'b0, 1'b0, 64'h18, 64'h0);
            waitDrain(60);
            checkOutput("rereq_rdata", if_rdata, memf(64'h18));
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
